// File: rtl/usb_rcv_pkg.sv
// Shared types and constants for the USB receive-side packet sequencer.
// Field lengths are 7 bits wide to match the bit counter.
package usb_rcv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SYNC     = 4'd1,
    ST_CHK_SYNC = 4'd2,
    ST_PID      = 4'd3,
    ST_CHK_PID  = 4'd4,
    ST_TOKEN    = 4'd5,
    ST_CRC5     = 4'd6,
    ST_DATA     = 4'd7,
    ST_CRC16    = 4'd8,
    ST_WAIT_EOP = 4'd9,
    ST_DONE     = 4'd10,
    ST_ERR      = 4'd11
  } rcv_state_t;

  localparam logic [1:0] PKT_NONE   = 2'b00;
  localparam logic [1:0] PKT_TOKEN  = 2'b01;
  localparam logic [1:0] PKT_DATA   = 2'b11;
  localparam logic [1:0] PKT_HSHAKE = 2'b10;

  localparam logic [6:0] SYNC_LEN  = 7'd8;
  localparam logic [6:0] PID_LEN   = 7'd8;
  localparam logic [6:0] CRC5_LEN  = 7'd5;
  localparam logic [6:0] CRC16_LEN = 7'd16;

  // True when the bit being accepted now completes a field of length len.
  function automatic logic field_last(input logic [6:0] cnt, input logic [6:0] len);
    return (cnt + 7'd1) == len;
  endfunction

endpackage

// File: rtl/usb_rcv_pid_check.sv
// Combinational PID validation: the upper nibble must be the complement of
// the lower nibble; the packet type is carried in the two low bits.
module usb_rcv_pid_check (
  input  logic [7:0] pid_i,
  output logic       pid_ok_o,
  output logic [1:0] pid_type_o
);

  assign pid_ok_o   = (pid_i[3:0] == ~pid_i[7:4]);
  assign pid_type_o = pid_i[1:0];

endmodule

// File: rtl/usb_rcv_ctrl.sv
// Receive packet sequencer: steers each decoded bit into one field shift
// register, validates SYNC/PID and reports packet type, completion and error.
module usb_rcv_ctrl
  import usb_rcv_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 64,
  parameter int unsigned TOKEN_BITS   = 11,
  parameter logic [7:0]  SYNC_PATTERN = 8'h80
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_valid,
  input  logic       eop,
  input  logic [7:0] rcv_sync,
  input  logic [7:0] rcv_pid,
  output logic       sync_shift_enable,
  output logic       pid_shift_enable,
  output logic       crc5_shift_enable,
  output logic       crc16_shift_enable,
  output logic       data_shift_enable,
  output logic [1:0] pkt_type,
  output logic       rcv_done,
  output logic       rcv_error
);

  localparam logic [6:0] DATA_LEN  = 7'(DATA_BITS);
  localparam logic [6:0] TOKEN_LEN = 7'(TOKEN_BITS);

  rcv_state_t state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [1:0] pkt_type_q, pkt_type_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       eop_seen_q, eop_seen_d;

  logic [6:0] field_len_s;
  rcv_state_t field_next_s;
  logic       err_s;
  logic       pid_ok_s;
  logic [1:0] pid_type_s;

  usb_rcv_pid_check u_pid_check (
    .pid_i      (rcv_pid),
    .pid_ok_o   (pid_ok_s),
    .pid_type_o (pid_type_s)
  );

  // Length and successor of the field currently being shifted.
  always_comb begin
    field_len_s  = SYNC_LEN;
    field_next_s = ST_CHK_SYNC;
    case (state_q)
      ST_PID:   begin field_len_s = PID_LEN;   field_next_s = ST_CHK_PID;  end
      ST_TOKEN: begin field_len_s = TOKEN_LEN; field_next_s = ST_CRC5;     end
      ST_CRC5:  begin field_len_s = CRC5_LEN;  field_next_s = ST_WAIT_EOP; end
      ST_DATA:  begin field_len_s = DATA_LEN;  field_next_s = ST_CRC16;    end
      ST_CRC16: begin field_len_s = CRC16_LEN; field_next_s = ST_WAIT_EOP; end
      default:  begin field_len_s = SYNC_LEN;  field_next_s = ST_CHK_SYNC; end
    endcase
  end

  // Next-state, counter and status logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pkt_type_d = pkt_type_q;
    done_d     = 1'b0;
    error_d    = error_q;
    eop_seen_d = eop_seen_q;
    err_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bit_valid && !eop) begin
          state_d = ST_SYNC;
          cnt_d   = 7'd1;
          error_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC, ST_PID, ST_TOKEN, ST_CRC5, ST_DATA, ST_CRC16: begin
        if (eop) begin
          err_s = 1'b1;
        end else if (bit_valid) begin
          if (field_last(cnt_q, field_len_s)) begin
            state_d = field_next_s;
            cnt_d   = 7'd0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_CHK_SYNC: begin
        if (eop || bit_valid || (rcv_sync != SYNC_PATTERN)) begin
          err_s = 1'b1;
        end else begin
          state_d = ST_PID;
        end
      end
      ST_CHK_PID: begin
        if (eop || bit_valid || !pid_ok_s) begin
          err_s = 1'b1;
        end else begin
          pkt_type_d = pid_type_s;
          case (pid_type_s)
            PKT_TOKEN:  state_d = ST_TOKEN;
            PKT_DATA:   state_d = ST_DATA;
            PKT_HSHAKE: state_d = ST_WAIT_EOP;
            default:    err_s   = 1'b1;
          endcase
        end
      end
      ST_WAIT_EOP: begin
        if (eop) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (bit_valid) begin
          err_s = 1'b1;
        end else begin
          state_d = ST_WAIT_EOP;
        end
      end
      ST_DONE: begin
        if (!eop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ERR: begin
        // Return to IDLE only once the SE0 of the bad packet has come and gone.
        if (eop) begin
          eop_seen_d = 1'b1;
        end else if (eop_seen_q) begin
          state_d    = ST_IDLE;
          eop_seen_d = 1'b0;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 7'd0;
      end
    endcase
    if (err_s) begin
      state_d    = ST_ERR;
      cnt_d      = 7'd0;
      error_d    = 1'b1;
      eop_seen_d = eop;
    end else begin
      eop_seen_d = eop_seen_d;
    end
  end

  // Per-bit field shift strobes; suppressed while reset is asserted.
  always_comb begin
    sync_shift_enable  = 1'b0;
    pid_shift_enable   = 1'b0;
    crc5_shift_enable  = 1'b0;
    crc16_shift_enable = 1'b0;
    data_shift_enable  = 1'b0;
    if (!n_rst && bit_valid) begin
      case (state_q)
        ST_IDLE:            sync_shift_enable  = !eop;
        ST_SYNC:            sync_shift_enable  = 1'b1;
        ST_PID:             pid_shift_enable   = 1'b1;
        ST_TOKEN, ST_DATA:  data_shift_enable  = 1'b1;
        ST_CRC5:            crc5_shift_enable  = 1'b1;
        ST_CRC16:           crc16_shift_enable = 1'b1;
        default:            sync_shift_enable  = 1'b0;
      endcase
    end else begin
      sync_shift_enable = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 7'd0;
      pkt_type_q <= PKT_NONE;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      eop_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pkt_type_q <= pkt_type_d;
      done_q     <= done_d;
      error_q    <= error_d;
      eop_seen_q <= eop_seen_d;
    end
  end

  assign pkt_type  = pkt_type_q;
  assign rcv_done  = done_q;
  assign rcv_error = error_q;

endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// Directed self-checking bench for usb_rcv_ctrl: good token/data/handshake
// packets, bad SYNC/PID, truncation, extra bit and mid-packet reset.
module tb_usb_rcv_ctrl;

  logic       clk;
  logic       n_rst;
  logic       bit_valid;
  logic       eop;
  logic [7:0] rcv_sync;
  logic [7:0] rcv_pid;
  logic       sync_shift_enable;
  logic       pid_shift_enable;
  logic       crc5_shift_enable;
  logic       crc16_shift_enable;
  logic       data_shift_enable;
  logic [1:0] pkt_type;
  logic       rcv_done;
  logic       rcv_error;

  int n_checks = 0;
  int n_errors = 0;

  int tot_sync = 0, tot_pid = 0, tot_crc5 = 0, tot_crc16 = 0, tot_data = 0;
  int tot_done = 0, tot_multi = 0;
  int b_sync, b_pid, b_crc5, b_crc16, b_data, b_done;

  usb_rcv_ctrl dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .bit_valid          (bit_valid),
    .eop                (eop),
    .rcv_sync           (rcv_sync),
    .rcv_pid            (rcv_pid),
    .sync_shift_enable  (sync_shift_enable),
    .pid_shift_enable   (pid_shift_enable),
    .crc5_shift_enable  (crc5_shift_enable),
    .crc16_shift_enable (crc16_shift_enable),
    .data_shift_enable  (data_shift_enable),
    .pkt_type           (pkt_type),
    .rcv_done           (rcv_done),
    .rcv_error          (rcv_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (sync_shift_enable)  tot_sync++;
    if (pid_shift_enable)   tot_pid++;
    if (crc5_shift_enable)  tot_crc5++;
    if (crc16_shift_enable) tot_crc16++;
    if (data_shift_enable)  tot_data++;
    if (rcv_done)           tot_done++;
    if ((int'(sync_shift_enable) + int'(pid_shift_enable) + int'(crc5_shift_enable) +
         int'(crc16_shift_enable) + int'(data_shift_enable)) > 1) tot_multi++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
      tick();
    end
  endtask

  task automatic snap();
    b_sync = tot_sync; b_pid = tot_pid; b_crc5 = tot_crc5;
    b_crc16 = tot_crc16; b_data = tot_data; b_done = tot_done;
  endtask

  task automatic check_counts(input string tag, input int es, input int ep, input int e5,
                              input int e16, input int ed, input int edone);
    check_eq({tag, "_sync_n"},  32'(tot_sync - b_sync),   32'(es));
    check_eq({tag, "_pid_n"},   32'(tot_pid - b_pid),     32'(ep));
    check_eq({tag, "_crc5_n"},  32'(tot_crc5 - b_crc5),   32'(e5));
    check_eq({tag, "_crc16_n"}, 32'(tot_crc16 - b_crc16), 32'(e16));
    check_eq({tag, "_data_n"},  32'(tot_data - b_data),   32'(ed));
    check_eq({tag, "_done_n"},  32'(tot_done - b_done),   32'(edone));
  endtask

  task automatic send_hdr(input logic [7:0] s, input logic [7:0] p);
    rcv_sync = s;
    rcv_pid  = p;
    send_bits(16);
  endtask

  task automatic end_good(input string tag);
    eop = 1'b1;
    tick();
    check_eq({tag, "_done_hi"}, 32'(rcv_done), 32'd1);
    tick();
    check_eq({tag, "_done_lo"}, 32'(rcv_done), 32'd0);
    eop = 1'b0;
    tick();
    tick();
  endtask

  task automatic end_bad();
    eop = 1'b1;
    tick();
    tick();
    eop = 1'b0;
    tick();
    tick();
  endtask

  task automatic token_pkt(input string tag);
    snap();
    send_hdr(8'h80, 8'hE1);
    send_bits(11 + 5);
    end_good(tag);
    check_counts(tag, 8, 8, 5, 0, 11, 1);
    check_eq({tag, "_type"}, 32'(pkt_type), 32'h1);
    check_eq({tag, "_err"}, 32'(rcv_error), 32'd0);
  endtask

  initial begin
    n_rst = 1'b1; bit_valid = 1'b0; eop = 1'b0;
    rcv_sync = 8'h00; rcv_pid = 8'h00;
    tick();
    tick();
    check_eq("rst_type", 32'(pkt_type), 32'h0);
    check_eq("rst_done", 32'(rcv_done), 32'd0);
    check_eq("rst_err", 32'(rcv_error), 32'd0);
    bit_valid = 1'b1;
    #1;
    check_eq("rst_sync_en", 32'(sync_shift_enable), 32'd0);
    bit_valid = 1'b0;
    n_rst = 1'b0;
    tick();

    // eop while idle is ignored
    end_bad();
    check_eq("idle_eop_err", 32'(rcv_error), 32'd0);

    token_pkt("token");

    snap();
    send_hdr(8'h80, 8'hC3);
    send_bits(64 + 16);
    end_good("data");
    check_counts("data", 8, 8, 0, 16, 64, 1);
    check_eq("data_type", 32'(pkt_type), 32'h3);
    check_eq("data_err", 32'(rcv_error), 32'd0);

    snap();
    send_hdr(8'h80, 8'hD2);
    end_good("hs");
    check_counts("hs", 8, 8, 0, 0, 0, 1);
    check_eq("hs_type", 32'(pkt_type), 32'h2);
    check_eq("hs_err", 32'(rcv_error), 32'd0);

    snap();
    rcv_sync = 8'h81;
    send_bits(8);
    check_eq("badsync_err", 32'(rcv_error), 32'd1);
    send_bits(2);
    check_counts("badsync", 8, 0, 0, 0, 0, 0);
    end_bad();
    check_eq("badsync_err_hold", 32'(rcv_error), 32'd1);

    snap();
    send_hdr(8'h80, 8'hE0);
    check_eq("badpid_err", 32'(rcv_error), 32'd1);
    end_bad();
    check_counts("badpid", 8, 8, 0, 0, 0, 0);
    check_eq("badpid_err_hold", 32'(rcv_error), 32'd1);
    bit_valid = 1'b1;
    tick();
    check_eq("err_clr_first_bit", 32'(rcv_error), 32'd0);
    bit_valid = 1'b0;
    tick();
    snap();
    send_bits(7);
    rcv_pid = 8'hE1;
    send_bits(8 + 11 + 5);
    end_good("after_err");
    check_counts("after_err", 7, 8, 5, 0, 11, 1);

    snap();
    send_hdr(8'h80, 8'hC3);
    send_bits(30);
    eop = 1'b1;
    tick();
    check_eq("trunc_err", 32'(rcv_error), 32'd1);
    tick();
    eop = 1'b0;
    tick();
    tick();
    check_counts("trunc", 8, 8, 0, 0, 30, 0);

    snap();
    send_hdr(8'h80, 8'hD2);
    send_bits(1);
    check_eq("extra_err", 32'(rcv_error), 32'd1);
    end_bad();
    check_counts("extra", 8, 8, 0, 0, 0, 0);

    send_hdr(8'h80, 8'hC3);
    send_bits(20);
    bit_valid = 1'b1;
    n_rst = 1'b1;
    #1;
    check_eq("midrst_data_en", 32'(data_shift_enable), 32'd0);
    tick();
    bit_valid = 1'b0;
    check_eq("midrst_type", 32'(pkt_type), 32'h0);
    check_eq("midrst_done", 32'(rcv_done), 32'd0);
    check_eq("midrst_err", 32'(rcv_error), 32'd0);
    n_rst = 1'b0;
    tick();
    token_pkt("post_rst");

    check_eq("one_hot_en", 32'(tot_multi), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
